// File: rtl/dense_argmax_pkg.sv
// Shared definitions for the dense stages: score width, index-width helper,
// argmax FSM states and the sign-magnitude ordering used by every comparator.
package dense_argmax_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } argmax_state_t;

    // Bits needed to hold 'value'; never less than one so CLASSES=1 still gets a port.
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        for (r = 0; v > 0; r++) begin
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

    // Strict a > b on sign-magnitude words; +0 and -0 are equal.
    function automatic logic sm_gt(input logic a_sign, input logic [31:0] a_mag,
                                   input logic b_sign, input logic [31:0] b_mag);
        logic both_zero;
        both_zero = (a_mag == 32'd0) && (b_mag == 32'd0);
        if (a_sign != b_sign) begin
            return !a_sign && !both_zero;
        end else if (!a_sign) begin
            return a_mag > b_mag;
        end else begin
            return a_mag < b_mag;
        end
    endfunction

endpackage

// File: rtl/float_gt.sv
// Combinational strict greater-than on two sign-magnitude score words.
module float_gt import dense_argmax_pkg::*; #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  a_gt_b
);

    localparam int MSB = DATA_WIDTH - 1;

    assign a_gt_b = sm_gt(a[MSB], 32'(a[MSB-1:0]), b[MSB], 32'(b[MSB-1:0]));

endmodule

// File: rtl/dense_argmax.sv
// Streaming argmax over CLASSES sign-magnitude scores per frame, one result pulse per frame.
// Define DENSE_ARGMAX_SCORES_EN to add a readable buffer of the scores seen so far.
module dense_argmax import dense_argmax_pkg::*; #(
    parameter int CLASSES    = 7,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear_i,
    input  logic                          valid_i,
    input  logic [DATA_WIDTH-1:0]         data_i,
`ifdef DENSE_ARGMAX_SCORES_EN
    input  logic [clogb2(CLASSES-1)-1:0]  rd_addr_i,
    output logic [DATA_WIDTH-1:0]         rd_data_o,
`endif
    output logic                          valid_o,
    output logic [clogb2(CLASSES-1)-1:0]  class_o,
    output logic [DATA_WIDTH-1:0]         max_o,
    output logic                          busy_o
);

    localparam int             IW   = clogb2(CLASSES - 1);
    localparam logic [IW-1:0]  LAST = IW'(CLASSES - 1);

    argmax_state_t           state;
    logic [IW-1:0]           count;
    logic [DATA_WIDTH-1:0]   run_max;
    logic [IW-1:0]           run_idx;

    logic                    data_gt;
    logic                    take;
    logic [DATA_WIDTH-1:0]   next_max;
    logic [IW-1:0]           next_idx;

    float_gt #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
        .a      (data_i),
        .b      (run_max),
        .a_gt_b (data_gt)
    );

    // The first score of a frame always wins; later ones only on strictly greater.
    assign take     = (state == IDLE) || data_gt;
    assign next_max = take ? data_i : run_max;
    assign next_idx = take ? count  : run_idx;
    assign busy_o   = (count != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            run_max <= '0;
            run_idx <= '0;
            valid_o <= 1'b0;
            class_o <= '0;
            max_o   <= '0;
        end else begin
            valid_o <= 1'b0;
            if (clear_i) begin
                state   <= IDLE;
                count   <= '0;
                run_max <= '0;
                run_idx <= '0;
            end else if (valid_i) begin
                if (count == LAST) begin
                    state   <= IDLE;
                    count   <= '0;
                    run_max <= '0;
                    run_idx <= '0;
                    valid_o <= 1'b1;
                    class_o <= next_idx;
                    max_o   <= next_max;
                end else begin
                    state   <= COLLECT;
                    count   <= count + 1'b1;
                    run_max <= next_max;
                    run_idx <= next_idx;
                end
            end
        end
    end

`ifdef DENSE_ARGMAX_SCORES_EN
    logic                  accept;
    logic [DATA_WIDTH-1:0] scores [CLASSES];

    assign accept = valid_i && !clear_i;

    // Survives clear_i on purpose so an aborted frame can still be inspected.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CLASSES; i++) begin
                scores[i] <= '0;
            end
        end else if (accept) begin
            scores[count] <= data_i;
        end
    end

    assign rd_data_o = (32'(rd_addr_i) < CLASSES) ? scores[rd_addr_i] : '0;
`endif

endmodule

// File: tb/tb_dense_argmax.sv
// Self-checking bench for dense_argmax (CLASSES=7, DATA_WIDTH=8): table vectors,
// hand-written abort/reset/back-to-back sequences and random frames against a value model.
module tb_dense_argmax;

    localparam int CLASSES = 7;

    logic       clk;
    logic       rst;
    logic       clear_i;
    logic       valid_i;
    logic [7:0] data_i;
    logic       valid_o;
    logic [2:0] class_o;
    logic [7:0] max_o;
    logic       busy_o;
`ifdef DENSE_ARGMAX_SCORES_EN
    logic [2:0] rd_addr_i;
    logic [7:0] rd_data_o;
`endif

    dense_argmax #(.CLASSES(CLASSES), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clear_i),
        .valid_i   (valid_i),
        .data_i    (data_i),
`ifdef DENSE_ARGMAX_SCORES_EN
        .rd_addr_i (rd_addr_i),
        .rd_data_o (rd_data_o),
`endif
        .valid_o   (valid_o),
        .class_o   (class_o),
        .max_o     (max_o),
        .busy_o    (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] s [7];
        logic [2:0] cls;
        logic [7:0] mx;
    } vec_t;

    vec_t       tbl [4];
    logic [7:0] frame [$];
    int         pulses [$];
    int         vectors;
    int         miscompares;
    int         cyc;
    logic       exp_valid;
    logic [2:0] exp_class;
    logic [7:0] exp_max;
    logic       exp_busy;

    // Signed integer value of a sign-magnitude word; both zeros map to 0.
    function automatic int smVal(input logic [7:0] w);
        return w[7] ? -int'(w[6:0]) : int'(w[6:0]);
    endfunction

    task automatic refModel();
        int best;
        best = 0;
        for (int i = 1; i < frame.size(); i++) begin
            if (smVal(frame[i]) > smVal(frame[best])) best = i;
        end
        exp_class = 3'(best);
        exp_max   = frame[best];
    endtask

    task automatic checkValue(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic checkOutput(input string name);
        vectors++;
        if ({valid_o, class_o, max_o, busy_o} !== {exp_valid, exp_class, exp_max, exp_busy}) begin
            miscompares++;
            $display("[TB] FAIL %s cyc %0d: got valid=%0b class=%0d max=%h busy=%0b, expected valid=%0b class=%0d max=%h busy=%0b",
                     name, cyc, valid_o, class_o, max_o, busy_o, exp_valid, exp_class, exp_max, exp_busy);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic c);
        @(negedge clk);
        valid_i = v;
        data_i  = d;
        clear_i = c;
        exp_valid = 1'b0;
        if (c) begin
            frame.delete();
        end else if (v) begin
            frame.push_back(d);
            if (frame.size() == CLASSES) begin
                refModel();
                exp_valid = 1'b1;
                frame.delete();
            end
        end
        exp_busy = (frame.size() != 0);
        @(posedge clk);
        #1;
        cyc++;
        if (valid_o) pulses.push_back(cyc);
        checkOutput("step");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    task automatic runTable(input int t, input bit gaps);
        for (int i = 0; i < CLASSES; i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) idle($urandom_range(1, 3));
            applyStimulus(1'b1, tbl[t].s[i], 1'b0);
        end
        checkValue($sformatf("table%0d_class", t), int'(class_o), int'(tbl[t].cls));
        checkValue($sformatf("table%0d_max", t), int'(max_o), int'(tbl[t].mx));
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        clear_i = 0; valid_i = 0; data_i = 0;
`ifdef DENSE_ARGMAX_SCORES_EN
        rd_addr_i = 0;
`endif
        exp_valid = 0; exp_class = 0; exp_max = 0; exp_busy = 0;

        tbl[0].s = '{8'h10, 8'h20, 8'h35, 8'h05, 8'h30, 8'h00, 8'h01}; tbl[0].cls = 3'd2; tbl[0].mx = 8'h35;
        tbl[1].s = '{8'h90, 8'h85, 8'hA0, 8'h81, 8'h88, 8'hFF, 8'h82}; tbl[1].cls = 3'd3; tbl[1].mx = 8'h81;
        tbl[2].s = '{8'h00, 8'h40, 8'h10, 8'h40, 8'h00, 8'h40, 8'h00}; tbl[2].cls = 3'd1; tbl[2].mx = 8'h40;
        tbl[3].s = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h80, 8'h80}; tbl[3].cls = 3'd0; tbl[3].mx = 8'h80;

        rst = 1'b1;
        #1;
        checkOutput("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 4; t++) begin
            runTable(t, 1'b0);
`ifdef DENSE_ARGMAX_SCORES_EN
            if (t == 0) begin
                rd_addr_i = 3'd2;
                #1;
                checkValue("rd_addr2", int'(rd_data_o), 8'h35);
                rd_addr_i = 3'd7;
                #1;
                checkValue("rd_addr7", int'(rd_data_o), 8'h00);
            end
`endif
        end

        // Same frame with random gaps must give the same answer.
        runTable(0, 1'b1);
        idle(2);

        // Two frames back to back: the 8th score lands with the first valid_o.
        pulses.delete();
        for (int i = 0; i < 2 * CLASSES; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
        idle(1);
        checkValue("b2b_pulses", pulses.size(), 2);
        if (pulses.size() == 2) checkValue("b2b_spacing", pulses[1] - pulses[0], CLASSES);

        // Abort after three scores, then a full frame.
        pulses.delete();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h7F, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1);
        runTable(0, 1'b0);
        idle(1);
        checkValue("abort_pulses", pulses.size(), 1);

        // clear_i and valid_i together drop the score.
        applyStimulus(1'b1, 8'h11, 1'b0);
        applyStimulus(1'b1, 8'h7F, 1'b1);
        runTable(1, 1'b0);

        // Asynchronous reset mid-frame.
        runTable(0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'h22, 1'b0);
        @(negedge clk);
        valid_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        frame.delete();
        exp_valid = 0; exp_class = 0; exp_max = 0; exp_busy = 0;
        checkOutput("async_reset");
        @(negedge clk);
        rst = 1'b0;
        runTable(0, 1'b0);

        // Random frames with random gaps.
        for (int f = 0; f < 15; f++) begin
            for (int i = 0; i < CLASSES; i++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
                applyStimulus(1'b1, 8'($urandom), 1'b0);
            end
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
